// File: rtl/systolic_pkg.sv
// Shared constants for the systolic tile scheduler: FSM encoding, array size,
// default drain length and the registered control-flag bundle.
package systolic_pkg;

    localparam int unsigned ARRAY_N          = 3;
    localparam int unsigned DRAIN_CYCLES_DEF = 4;
    localparam int unsigned ST_W             = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [ST_W-1:0] ST_FIRE  = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd4;

    // Single-bit scheduler outputs, registered together as one bundle.
    typedef struct packed {
        logic cmd_ready;
        logic ld_req;
        logic array_start;
        logic acc_clr;
        logic acc_en;
        logic wb_valid;
        logic done;
        logic busy;
    } sched_ctrl_t;

endpackage

// File: rtl/systolic_tile_scheduler_if.sv
// Handshake/bus bundle between the scheduler and its neighbours
// (command front-end, operand loader, valid pipeline, accumulator, writeback).
interface systolic_tile_scheduler_if #(
    parameter int unsigned CNT_W = 8
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_tiles;
    logic             ld_req;
    logic             ld_ack;
    logic [CNT_W-1:0] tile_idx;
    logic             array_start;
    logic             array_busy;
    logic             acc_clr;
    logic             acc_en;
    logic             wb_valid;
    logic             wb_ready;
    logic             done;
    logic             busy;

    // Scheduler side.
    modport master (
        input  cmd_valid, cmd_tiles, ld_ack, array_busy, wb_ready,
        output cmd_ready, ld_req, tile_idx, array_start, acc_clr, acc_en,
               wb_valid, done, busy
    );

    // Environment side.
    modport slave (
        output cmd_valid, cmd_tiles, ld_ack, array_busy, wb_ready,
        input  cmd_ready, ld_req, tile_idx, array_start, acc_clr, acc_en,
               wb_valid, done, busy
    );

endinterface

// File: rtl/drain_timer.sv
// Loadable saturating down-counter timing the minimum DRAIN residency.
module drain_timer #(
    parameter int unsigned DRN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DRN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [DRN_W-1:0] cnt_d;
    logic [DRN_W-1:0] cnt_q;

    // Next count: load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - DRN_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Sequences one matrix-multiply job over K tiles on the 3x3 systolic array:
// load operands, fire the valid pipeline, drain, repeat, then write back.
module systolic_tile_scheduler
    import systolic_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned DRN_W        = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    systolic_tile_scheduler_if.master   bus
);

    logic [ST_W-1:0]  state_d;
    logic [ST_W-1:0]  state_q;
    logic [CNT_W-1:0] tiles_d;
    logic [CNT_W-1:0] tiles_q;
    logic [CNT_W-1:0] tile_idx_d;
    logic [CNT_W-1:0] tile_idx_q;
    sched_ctrl_t      ctrl_d;
    sched_ctrl_t      ctrl_q;

    logic accept_c;
    logic last_tile_c;
    logic drn_load_c;
    logic drn_dec_c;
    logic drn_zero_c;

    assign last_tile_c = (tile_idx_q == (tiles_q - CNT_W'(1)));
    assign drn_load_c  = (state_q == ST_FIRE);
    assign drn_dec_c   = (state_q == ST_DRAIN);

    drain_timer #(
        .DRN_W (DRN_W)
    ) u_drain_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (drn_load_c),
        .load_val (DRN_W'(DRAIN_CYCLES - 1)),
        .dec      (drn_dec_c),
        .zero_c   (drn_zero_c)
    );

    // Next-state and next-output logic; outputs are decoded from the next state
    // so that every output is registered yet aligned with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        tiles_d    = tiles_q;
        tile_idx_d = tile_idx_q;
        accept_c   = 1'b0;
        ctrl_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && ctrl_q.cmd_ready) begin
                    accept_c   = 1'b1;
                    tiles_d    = bus.cmd_tiles;
                    tile_idx_d = '0;
                    if (bus.cmd_tiles == '0) begin
                        ctrl_d.done = 1'b1;
                    end else begin
                        ctrl_d.acc_clr = 1'b1;
                        state_d        = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.ld_ack) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drn_zero_c && !bus.array_busy) begin
                    if (last_tile_c) begin
                        state_d = ST_WRITE;
                    end else begin
                        tile_idx_d = tile_idx_q + CNT_W'(1);
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.wb_ready) begin
                    ctrl_d.done = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ctrl_d.cmd_ready   = (state_d == ST_IDLE) && !accept_c;
        ctrl_d.ld_req      = (state_d == ST_LOAD);
        ctrl_d.array_start = (state_d == ST_FIRE);
        ctrl_d.acc_en      = (state_d == ST_FIRE) || (state_d == ST_DRAIN);
        ctrl_d.wb_valid    = (state_d == ST_WRITE);
        ctrl_d.busy        = (state_d != ST_IDLE);
    end

    // State, job context and output registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tiles_q    <= '0;
            tile_idx_q <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            tiles_q    <= tiles_d;
            tile_idx_q <= tile_idx_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign bus.cmd_ready   = ctrl_q.cmd_ready;
    assign bus.ld_req      = ctrl_q.ld_req;
    assign bus.tile_idx    = tile_idx_q;
    assign bus.array_start = ctrl_q.array_start;
    assign bus.acc_clr     = ctrl_q.acc_clr;
    assign bus.acc_en      = ctrl_q.acc_en;
    assign bus.wb_valid    = ctrl_q.wb_valid;
    assign bus.done        = ctrl_q.done;
    assign bus.busy        = ctrl_q.busy;

endmodule
